// File: rtl/deserializer.sv
// deserializer
//   Reassembles an MSB-first serial stream into parallel words. A frame is a
//   run of consecutive cycles with ser_data_val_i high. Full-width frames are
//   emitted on the edge that captures the last bit. Shorter frames are emitted
//   when the valid run ends: frames of 3 or more bits are emitted left-aligned
//   with their bit count, and frames of 1 or 2 bits are dropped and flagged.
//
// Ports
//   clk_i             clock, posedge
//   arst_n_i          async reset, active low
//   ser_data_i        serial bit, frame MSB first
//   ser_data_val_i    serial bit valid
//   deser_data_o      reassembled word, MSB-aligned, unused low bits zero
//   deser_data_mod_o  valid bit count of deser_data_o (0 = full width)
//   deser_data_val_o  one-cycle strobe for deser_data_o/deser_data_mod_o
//   short_frame_o     one-cycle strobe: 1- or 2-bit frame discarded
//   busy_o            frame collection in progress
module deserializer #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      short_frame_o,
  output logic                      busy_o
);

  localparam int CW = DATA_MOD_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BUS_WIDTH - 1);
  localparam logic [CW-1:0] MIN_KEEP = CW'(3);
  localparam logic [DATA_BUS_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_BUS_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    RECV_S = 2'd1
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [DATA_BUS_WIDTH-1:0] r_shift_buf;
  logic [CW-1:0]             r_bit_cnt;

  logic                      w_capture, w_full, w_partial, w_short;
  logic [DATA_BUS_WIDTH-1:0] w_bit_vec, w_shift_nxt;

  // Each bit is written straight to its final slot (DATA_BUS_WIDTH-1-bit_cnt),
  // so the buffer is always MSB-aligned with zeros below the captured bits and
  // a partial frame needs no realignment shift.
  assign w_bit_vec   = MSB_ONE >> r_bit_cnt;
  assign w_shift_nxt = ser_data_i ? (r_shift_buf | w_bit_vec) : r_shift_buf;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_full      = 1'b0;
    w_partial   = 1'b0;
    w_short     = 1'b0;
    case (r_state)
      IDLE_S: begin
        if (ser_data_val_i) begin
          w_capture   = 1'b1;
          w_state_nxt = RECV_S;
        end
      end
      RECV_S: begin
        if (ser_data_val_i) begin
          w_capture = 1'b1;
          if (r_bit_cnt == LAST_IDX) begin
            w_full      = 1'b1;
            w_state_nxt = IDLE_S;
          end
        end else begin
          // Valid run ended early: keep 3+ bit frames, flag 1-2 bit runs.
          if (r_bit_cnt >= MIN_KEEP) w_partial = 1'b1;
          else                       w_short   = 1'b1;
          w_state_nxt = IDLE_S;
        end
      end
      default: begin
`ifdef SYNTHESIS
        w_state_nxt = IDLE_S;
`else
        w_state_nxt = state_t'('x);
`endif
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE_S;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_shift_buf      <= '0;
      r_bit_cnt        <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
      short_frame_o    <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      short_frame_o    <= 1'b0;
      if (w_full) begin
        deser_data_o     <= w_shift_nxt;
        deser_data_mod_o <= '0;
        deser_data_val_o <= 1'b1;
        r_shift_buf      <= '0;
        r_bit_cnt        <= '0;
      end else if (w_partial) begin
        deser_data_o     <= r_shift_buf;
        deser_data_mod_o <= r_bit_cnt[DATA_MOD_WIDTH-1:0];
        deser_data_val_o <= 1'b1;
        r_shift_buf      <= '0;
        r_bit_cnt        <= '0;
      end else if (w_short) begin
        short_frame_o    <= 1'b1;
        r_shift_buf      <= '0;
        r_bit_cnt        <= '0;
      end else if (w_capture) begin
        r_shift_buf      <= w_shift_nxt;
        r_bit_cnt        <= r_bit_cnt + 1'b1;
      end
    end
  end

  assign busy_o = (r_state == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

  localparam int W = 16;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ser_d = 1'b0;
  logic         ser_v = 1'b0;
  logic [W-1:0] dat_o;
  logic [M-1:0] mod_o;
  logic         val_o, short_o, busy_o;

  deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M)) dut (
    .clk_i            (clk),
    .arst_n_i         (rst_n),
    .ser_data_i       (ser_d),
    .ser_data_val_i   (ser_v),
    .deser_data_o     (dat_o),
    .deser_data_mod_o (mod_o),
    .deser_data_val_o (val_o),
    .short_frame_o    (short_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int short_cnt = 0;
  logic [W-1:0] q_data[$];
  logic [M-1:0] q_mod[$];
  int           q_cyc[$];

  always @(posedge clk) cyc++;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (val_o) begin
      q_data.push_back(dat_o);
      q_mod.push_back(mod_o);
      q_cyc.push_back(cyc);
    end
    if (short_o) short_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    q_data.delete();
    q_mod.delete();
    q_cyc.delete();
    short_cnt = 0;
  endtask

  // Drive n bits of an MSB-aligned word, one per cycle, MSB first.
  task automatic send(input logic [W-1:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      ser_v = 1'b1;
      ser_d = w[W-1-k];
      tick();
    end
    ser_v = 1'b0;
    ser_d = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] word;
    int           nbits;
    logic [W-1:0] exp_data;
    logic [M-1:0] exp_mod;
    int           exp_val;
    int           exp_short;
  } vec_t;

  vec_t vecs[8];

  logic [W-1:0] exp_q_data[$];
  logic [M-1:0] exp_q_mod[$];

  initial begin
    vecs[0] = '{16'hA5C3, 16, 16'hA5C3, 4'd0,  1, 0};
    vecs[1] = '{16'hB000,  5, 16'hB000, 4'd5,  1, 0};  // 1,0,1,1,0
    vecs[2] = '{16'hC000,  2, 16'hB000, 4'd5,  0, 1};  // short: output held
    vecs[3] = '{16'h8000,  1, 16'hB000, 4'd5,  0, 1};
    vecs[4] = '{16'hE000,  3, 16'hE000, 4'd3,  1, 0};  // minimum kept frame
    vecs[5] = '{16'hFFFF, 15, 16'hFFFE, 4'd15, 1, 0};  // longest partial
    vecs[6] = '{16'h0001, 16, 16'h0001, 4'd0,  1, 0};
    vecs[7] = '{16'h9000,  4, 16'h9000, 4'd4,  1, 0};

    // Reset state
    #2;
    chk("rst_data", dat_o, 0);
    chk("rst_mod", mod_o, 0);
    chk("rst_val", val_o, 0);
    chk("rst_short", short_o, 0);
    chk("rst_busy", busy_o, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Table-driven frames, each followed by an idle gap
    foreach (vecs[i]) begin
      clr_mon();
      send(vecs[i].word, vecs[i].nbits);
      tick(); tick(); tick();
      chk($sformatf("v%0d_nstrobe", i), q_data.size(), vecs[i].exp_val);
      chk($sformatf("v%0d_nshort", i), short_cnt, vecs[i].exp_short);
      chk($sformatf("v%0d_data", i), dat_o, vecs[i].exp_data);
      chk($sformatf("v%0d_mod", i), mod_o, vecs[i].exp_mod);
      chk($sformatf("v%0d_busy", i), busy_o, 0);
    end

    // Full frame latency and busy
    clr_mon();
    for (int k = 0; k < 16; k++) begin
      ser_v = 1'b1;
      ser_d = k[0];  // 0101... -> 0x5555
      tick();
      if (k == 7) chk("lat_busy_mid", busy_o, 1);
      if (k < 15) chk("lat_no_early", val_o, 0);
    end
    ser_v = 1'b0;
    chk("lat_val", val_o, 1);
    chk("lat_data", dat_o, 16'h5555);
    chk("lat_mod", mod_o, 0);
    chk("lat_busy_end", busy_o, 0);
    tick();
    chk("lat_val_1cyc", val_o, 0);
    chk("lat_hold", dat_o, 16'h5555);

    // Back-to-back full frames, no gap
    clr_mon();
    send(16'h1234, 16);
    send(16'hFFFF, 16);
    tick(); tick();
    chk("b2b_count", q_data.size(), 2);
    if (q_data.size() == 2) begin
      chk("b2b_d0", q_data[0], 16'h1234);
      chk("b2b_d1", q_data[1], 16'hFFFF);
      chk("b2b_m0", q_mod[0], 0);
      chk("b2b_m1", q_mod[1], 0);
      chk("b2b_gap", q_cyc[1] - q_cyc[0], 16);
    end

    // Reset mid-frame
    clr_mon();
    for (int k = 0; k < 7; k++) begin
      ser_v = 1'b1;
      ser_d = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_data", dat_o, 0);
    chk("mrst_busy", busy_o, 0);
    ser_v = 1'b0;
    tick(); tick();
    chk("mrst_val", val_o, 0);
    chk("mrst_mod", mod_o, 0);
    rst_n = 1'b1;
    tick();
    send(16'h00FF, 16);
    tick(); tick();
    chk("mrst_count", q_data.size(), 1);
    if (q_data.size() == 1) begin
      chk("mrst_next_data", q_data[0], 16'h00FF);
      chk("mrst_next_mod", q_mod[0], 0);
    end
    chk("mrst_short", short_cnt, 0);

    // Serializer-style random traffic, mod in {0,3..15}
    clr_mon();
    exp_q_data.delete();
    exp_q_mod.delete();
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d, mask;
      int r, m, n;
      d = W'($urandom);
      r = $urandom_range(0, 13);
      m = (r == 0) ? 0 : r + 2;
      n = (m == 0) ? 16 : m;
      mask = 16'hFFFF << (16 - n);
      exp_q_data.push_back(d & mask);
      exp_q_mod.push_back(M'(m));
      send(d, n);
      if (n != 16 || $urandom_range(0, 1) == 1) tick();
    end
    tick(); tick(); tick();
    chk("rnd_count", q_data.size(), exp_q_data.size());
    chk("rnd_short", short_cnt, 0);
    if (q_data.size() == exp_q_data.size()) begin
      foreach (exp_q_data[i]) begin
        chk($sformatf("rnd%0d_data", i), q_data[i], exp_q_data[i]);
        chk($sformatf("rnd%0d_mod", i), q_mod[i], exp_q_mod[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
